// File: rtl/div_param.sv
// Parametrised radix-2 restoring divider for the EX stage.
// Optional early-out skips the leading zeros of |dividend|.
`timescale 1ns/1ps
module div_param #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        FREE,
        BYZERO,
        ON,
        FIX,
        END
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] abs1, abs2;
    logic [CW-1:0]    lz, k, n;
    logic             accept, op2_zero;

    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dz;

    logic [WIDTH:0]   cand;
    logic [WIDTH-1:0] trial;
    logic             neg;

    assign accept   = start_i && !annul_i;
    assign op2_zero = (opdata2_i == '0);

    assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Upward scan: the highest set bit wins; all-zero leaves WIDTH.
    always_comb begin
        lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (abs1[i]) begin
                lz = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign k = EARLY_OUT ? lz : '0;
    assign n = CW'(WIDTH) - k;

    // cand < 2*dvs, so a WIDTH-bit trial difference is exact when kept.
    assign cand  = {pr, sr[WIDTH-1]};
    assign neg   = (cand < {1'b0, dvs});
    assign trial = cand[WIDTH-1:0] - dvs;

    assign busy_o = (state != FREE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FREE: begin
                if (accept) begin
                    if (op2_zero) begin
                        state_nx = BYZERO;
                    end else if (n == '0) begin
                        state_nx = FIX;
                    end else begin
                        state_nx = ON;
                    end
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nx = FREE;
                end else if (cnt == CW'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX, BYZERO: begin
                state_nx = annul_i ? FREE : END;
            end
            END: begin
                if (!start_i) begin
                    state_nx = FREE;
                end
            end
            default: state_nx = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvs        <= '0;
            pr         <= '0;
            sr         <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            unique case (state)
                FREE: begin
                    result_o   <= '0;
                    ready_o    <= 1'b0;
                    div_zero_o <= 1'b0;
                    if (accept) begin
                        neg_q <= signed_div_i &&
                                 (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                        dvs   <= abs2;
                        pr    <= '0;
                        sr    <= op2_zero ? '0 : (abs1 << k);
                        cnt   <= n;
                        dz    <= op2_zero;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        sr  <= {sr[WIDTH-2:0], ~neg};
                        pr  <= neg ? cand[WIDTH-1:0] : trial;
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (neg_q) begin
                        sr <= -sr;
                    end
                    if (neg_r) begin
                        pr <= -pr;
                    end
                end
                BYZERO: begin
                    sr <= '0;
                    pr <= '0;
                end
                END: begin
                    if (start_i) begin
                        result_o   <= {pr, sr};
                        ready_o    <= 1'b1;
                        div_zero_o <= dz;
                    end else begin
                        result_o   <= '0;
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Scoreboard bench for div_param: 32-bit (early-out off/on)
// and 8-bit instances, directed vectors.
`timescale 1ns/1ps
module tb_div_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, annul, sgn;
    logic [31:0] a, b;
    logic [63:0] res0, res1;
    logic        rdy0, rdy1, bsy0, bsy1, dz0, dz1;

    logic        start8, annul8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, bsy8, dz8;

    div_param #(.WIDTH(32), .EARLY_OUT(1'b0)) d0 (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
        .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
        .result_o(res0), .ready_o(rdy0), .busy_o(bsy0),
        .div_zero_o(dz0)
    );

    div_param #(.WIDTH(32), .EARLY_OUT(1'b1)) d1 (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
        .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
        .result_o(res1), .ready_o(rdy1), .busy_o(bsy1),
        .div_zero_o(dz1)
    );

    div_param #(.WIDTH(8), .EARLY_OUT(1'b1)) d8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8),
        .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
        .result_o(res8), .ready_o(rdy8), .busy_o(bsy8),
        .div_zero_o(dz8)
    );

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
        int          stamp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q8[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Monitors: compare on each rising ready edge.
    logic p0 = 1'b0, p1 = 1'b0, p8 = 1'b0;

    always @(negedge clk) begin
        if (rdy0 && !p0) begin
            chk("d0_pending", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("d0_result", res0, e.res);
                chk("d0_divzero", 64'(dz0), 64'(e.dz));
                chk("d0_latency", 64'(cyc - e.stamp - 1), 64'(e.lat));
            end
        end
        p0 = rdy0;
    end

    always @(negedge clk) begin
        if (rdy1 && !p1) begin
            chk("d1_pending", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_result", res1, e.res);
                chk("d1_divzero", 64'(dz1), 64'(e.dz));
                chk("d1_latency", 64'(cyc - e.stamp - 1), 64'(e.lat));
            end
        end
        p1 = rdy1;
    end

    always @(negedge clk) begin
        if (rdy8 && !p8) begin
            chk("d8_pending", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                chk("d8_result", 64'(res8), e.res);
                chk("d8_divzero", 64'(dz8), 64'(e.dz));
                chk("d8_latency", 64'(cyc - e.stamp - 1), 64'(e.lat));
            end
        end
        p8 = rdy8;
    end

    task automatic run32(input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] e,
                         input logic ez, input int l0, input int l1);
        exp_t t;
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        t.res = e;
        t.dz  = ez;
        t.stamp = cyc;
        t.lat = l0;
        q0.push_back(t);
        t.lat = l1;
        q1.push_back(t);
        @(negedge clk);
        a   = ~x;
        b   = y ^ 32'h5a5a_0001;
        sgn = ~s;
        for (int i = 0; i < 80 && !(rdy0 && rdy1); i++) @(negedge clk);
        chk("ready_seen", 64'(rdy0 && rdy1), 64'd1);
        repeat (2) @(negedge clk);
        chk("hold_ready", 64'(rdy0 && rdy1), 64'd1);
        chk("hold_res0", res0, e);
        chk("hold_res1", res1, e);
        start = 1'b0;
        @(negedge clk);
        chk("drop_res", res0 | res1, 64'd0);
        chk("drop_flags", 64'({rdy0, rdy1, dz0, dz1, bsy0, bsy1}), 64'd0);
    endtask

    task automatic run8(input logic s, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] e,
                        input int l);
        exp_t t;
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = s;
        a8     = x;
        b8     = y;
        t.res  = 64'(e);
        t.dz   = 1'b0;
        t.stamp = cyc;
        t.lat  = l;
        q8.push_back(t);
        @(negedge clk);
        a8 = ~x;
        b8 = 8'h00;
        for (int i = 0; i < 40 && !rdy8; i++) @(negedge clk);
        chk("d8_ready_seen", 64'(rdy8), 64'd1);
        start8 = 1'b0;
        @(negedge clk);
        chk("d8_drop", 64'({res8, rdy8, bsy8}), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start8 = 1'b0; annul8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk("reset_res", res0 | res1 | 64'(res8), 64'd0);
        chk("reset_flags",
            64'({rdy0, rdy1, rdy8, bsy0, bsy1, bsy8, dz0, dz1, dz8}), 64'd0);
        rst = 1'b1;

        run32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34, 9);
        run32(1'b1, 32'hFFFF_FFF9, 32'd2,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 34, 5);
        run32(1'b1, 32'd7, 32'hFFFF_FFFE,
              {32'd1, 32'hFFFF_FFFD}, 1'b0, 34, 5);
        run32(1'b0, 32'h1234, 32'd0, 64'd0, 1'b1, 2, 2);
        run32(1'b0, 32'd5, 32'd3, {32'd2, 32'd1}, 1'b0, 34, 5);
        run32(1'b0, 32'd0, 32'd9, 64'd0, 1'b0, 34, 2);
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              {32'd0, 32'h8000_0000}, 1'b0, 34, 34);

        run8(1'b1, 8'h80, 8'hFF, 16'h0080, 10);
        run8(1'b0, 8'd200, 8'd7, 16'h041C, 10);
        run8(1'b1, 8'h80, 8'd3, 16'hFED6, 10);

        // Flush in the middle of the iterations.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'hFFFF_FFFF; b = 32'd3;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy", 64'({bsy0, bsy1}), 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_quiet", 64'({rdy0, rdy1}), 64'd0);
        run32(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 34, 6);

        // Asynchronous reset while iterating.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'hFFFF_FFFF; b = 32'd5;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'({bsy0, bsy1}), 64'b11);
        #2 rst = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_res", res0 | res1, 64'd0);
        chk("rst_flags", 64'({rdy0, rdy1, bsy0, bsy1, dz0, dz1}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run32(1'b0, 32'd200, 32'd9, {32'd2, 32'd22}, 1'b0, 34, 10);

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(q0.size() + q1.size() + q8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/div_param.md
Name: div_param

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the EX stage; next generation of the fixed 32-bit core divider.
- Adds:
  - a WIDTH parameter;
  - optional early termination that skips the dividend's leading zeros;
  - operand latching at start;
  - explicit busy and divide-by-zero outputs;
  - a defined signed-overflow result.
- Keeps the start/annul/ready handshake the EX stage and pipeline control already use.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- EARLY_OUT, 1, 1 = skip leading-zero iterations of |dividend|; 0 = always run WIDTH iterations.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets immediately, release is synchronous to clk.
- start_i  in  1  request a divide; level, held high by EX until the result is consumed.
- annul_i  in  1  flush; cancels a pending or running divide.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  WIDTH  dividend; sampled with start.
- opdata2_i  in  WIDTH  divisor; sampled with start.
- result_o  out  2*WIDTH  {remainder, quotient}; remainder in [2W-1:W], quotient in [W-1:0].
- ready_o  out  1  result valid.
- busy_o  out  1  high in every state except FREE.
- div_zero_o  out  1  high together with ready_o when the divisor was zero.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE; result_o=0, ready_o=0, busy_o=0, div_zero_o=0; counter, shift register and operand latches cleared.
- States: FREE, BYZERO, ON, FIX, END.
- FREE:
  - if start_i=1 and annul_i=0: latch signed_div_i, sign bits, |op1| and |op2|.
    - |x| is the two's complement negation when signed and the MSB is set, else x.
    - if opdata2_i=0, go to BYZERO.
    - else go to ON.
  - otherwise hold result_o=0, ready_o=0, div_zero_o=0.
- Early out:
  - k = leading-zero count of |op1| if EARLY_OUT=1, else k=0.
  - k=WIDTH when |op1|=0.
  - Preload the shift register with |op1| << k; iteration count = WIDTH-k.
  - Skipped quotient bits are 0.
- ON, one iteration per cycle:
  - trial = partial_remainder - |op2|, computed WIDTH+1 bits wide.
  - trial non-negative: shift in quotient bit 1 and keep trial.
  - trial negative: shift in 0 and keep the partial remainder.
  - After the last iteration go to FIX; with zero iterations, go straight to FIX.
- FIX:
  - negate the quotient if signed and the latched operand signs differ;
  - negate the remainder if signed and the latched dividend was negative (remainder takes the dividend's sign);
  - go to END.
- Signed overflow (MIN / -1): quotient = MIN (wraps), remainder = 0; no flag.
- BYZERO: next cycle go to END with quotient=0, remainder=0, div_zero_o armed.
- END:
  - ready_o=1 and result_o is valid.
  - Hold both while start_i=1.
  - When start_i=0: go to FREE; ready_o, div_zero_o and result_o return to 0 on the next edge.
- Latency (start sampled at edge E0, ready_o high after edge):
  - normal divide: E0 + (WIDTH-k) + 2;
  - divide by zero: E0 + 2.
- annul_i=1 in ON, FIX or BYZERO: go to FREE next edge; no ready_o pulse; outputs stay 0.
- annul_i in END is ignored; the handshake completes normally.
- start_i while busy is ignored. Operand changes after the start sample have no effect.
- A new divide can be accepted in FREE on the cycle after END exits.

Test Plan:
- WIDTH=32, EARLY_OUT=0, unsigned 100/7 -> quotient=14, remainder=2, ready_o high 34 cycles after start; held until start_i drops, then result_o=0 next cycle.
- Signed cases, WIDTH=32:
  - 0xFFFFFFF9 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: 0x1234 / 0 -> ready_o and div_zero_o high 2 cycles after start, result_o=0; opdata2_i changes mid-op do not matter.
- EARLY_OUT=1, 5/3 -> k=29, ready after 5 cycles, quotient=1, remainder=2; 0/9 -> ready after 2 cycles, result 0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero_o=0. Also repeat with WIDTH=8: 0x80 / 0xFF -> quotient=0x80, remainder=0.
- Annul and reset:
  - annul_i pulsed at iteration 10 -> back to FREE, no ready_o; a following 9/3 gives quotient=3.
  - rst asserted mid-ON -> all outputs 0 immediately and state FREE.
